// File: rtl/countdown_timer_pkg.sv
// Shared timer state encoding, reused by the timer and future PWM blocks.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with expiry pulse and optional auto-reload for periodic ticks.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic [7:0]       decrement,
  input  logic             enable,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic             done_next;
  logic [WIDTH-1:0] step;

  assign step  = {{(WIDTH-8){1'b0}}, decrement};
  assign ready = (state == IDLE) || (state == EXPIRED);
  assign busy  = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      done   <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    done_next   = 1'b0;
    if (abort) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE, EXPIRED: begin
          if (start) begin
            reload_next = load_value;
            if (load_value == '0) begin
              // Zero load expires at once; with reload it must not loop on a zero period.
              count_next = '0;
              done_next  = 1'b1;
              state_next = RELOAD ? IDLE : EXPIRED;
            end else begin
              count_next = load_value;
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (enable && (step != '0)) begin
            if (count > step) begin
              count_next = count - step;
            end else begin
              done_next = 1'b1;
              if (RELOAD) begin
                count_next = reload;
              end else begin
                count_next = '0;
                state_next = EXPIRED;
              end
            end
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer, one-shot and auto-reload instances side by side.
module tb_countdown_timer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          enable = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic [7:0]    decrement = '0;
  logic          ready0, busy0, done0, ready1, busy1, done1;
  logic [W-1:0]  count0, count1;

  int compared = 0;
  int mismatched = 0;

  // Reference: per instance, whether a countdown is in progress and what remains.
  bit              m_run  [2];
  bit              m_done [2];
  longint unsigned m_cnt  [2];
  longint unsigned m_rel  [2];

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .RELOAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .load_value(load_value),
    .decrement(decrement), .enable(enable), .abort(abort),
    .ready(ready0), .busy(busy0), .done(done0), .count(count0)
  );

  countdown_timer #(.WIDTH(W), .RELOAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .load_value(load_value),
    .decrement(decrement), .enable(enable), .abort(abort),
    .ready(ready1), .busy(busy1), .done(done1), .count(count1)
  );

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_run[r] = 0; m_done[r] = 0; m_cnt[r] = 0; m_rel[r] = 0;
    end
  endtask

  task automatic model_edge();
    for (int r = 0; r < 2; r++) begin
      bit was_running;
      was_running = m_run[r];
      m_done[r] = 0;
      if (!rst_n) begin
        m_run[r] = 0; m_cnt[r] = 0; m_rel[r] = 0;
      end else if (abort) begin
        m_run[r] = 0; m_cnt[r] = 0;
      end else if (!was_running) begin
        if (start) begin
          m_rel[r] = load_value;
          m_cnt[r] = load_value;
          if (load_value == 0) m_done[r] = 1;
          else m_run[r] = 1;
        end
      end else if (enable && decrement != 0) begin
        if (m_cnt[r] > decrement) begin
          m_cnt[r] = m_cnt[r] - decrement;
        end else begin
          m_done[r] = 1;
          if (r == 1) m_cnt[r] = m_rel[r];
          else begin m_cnt[r] = 0; m_run[r] = 0; end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " count0"}, 64'(count0), 64'(m_cnt[0]));
    chk({tag, " ready0"}, 64'(ready0), 64'(!m_run[0]));
    chk({tag, " busy0"},  64'(busy0),  64'(m_run[0]));
    chk({tag, " done0"},  64'(done0),  64'(m_done[0]));
    chk({tag, " count1"}, 64'(count1), 64'(m_cnt[1]));
    chk({tag, " ready1"}, 64'(ready1), 64'(!m_run[1]));
    chk({tag, " busy1"},  64'(busy1),  64'(m_run[1]));
    chk({tag, " done1"},  64'(done1),  64'(m_done[1]));
  endtask

  task automatic go(input int lv, input int dec);
    load_value = W'(lv); decrement = 8'(dec); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; cyc(); abort = 1'b0;
    chk_all("abort");
  endtask

  initial begin
    model_reset();
    #3;
    chk_all("reset");
    @(negedge clk) rst_n = 1'b1;
    enable = 1'b1;

    // Basic countdown 10,7,4,1,0
    go(10, 3);
    chk_all("basic load");
    chk("basic first", 64'(count0), 64'd10);
    for (int i = 0; i < 4; i++) begin cyc(); chk_all("basic step"); end
    chk("basic zero", 64'(count0), 64'd0);
    chk("basic done", 64'(done0), 64'd1);
    cyc(); chk_all("basic expired");
    chk("basic done once", 64'(done0), 64'd0);
    chk("basic ready", 64'(ready0), 64'd1);
    do_abort();

    // Pause, then abort beats start
    go(100, 1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin cyc(); chk_all("pause"); end
    chk("pause hold", 64'(count0), 64'd100);
    enable = 1'b1;
    cyc(); chk_all("resume");
    abort = 1'b1; start = 1'b1; load_value = W'(7);
    cyc(); chk_all("abort+start");
    chk("abort count", 64'(count0), 64'd0);
    chk("abort ready", 64'(ready0), 64'd1);
    abort = 1'b0; start = 1'b0;

    // Load zero expires immediately, no RUN
    go(0, 1);
    chk_all("load0");
    chk("load0 done", 64'(done0), 64'd1);
    chk("load0 busy1", 64'(busy1), 64'd0);
    cyc(); chk_all("load0 after");

    // Exact single-step expiry
    go(5, 5);
    chk_all("eq load");
    cyc(); chk_all("eq step");
    chk("eq done", 64'(done0), 64'd1);
    do_abort();

    // Large step must not wrap
    go(4, 255);
    cyc(); chk_all("nowrap");
    chk("nowrap count", 64'(count0), 64'd0);
    do_abort();

    // Zero step freezes the count
    go(9, 0);
    for (int i = 0; i < 4; i++) begin cyc(); chk_all("dec0"); end
    chk("dec0 frozen", 64'(count0), 64'd9);
    do_abort();

    // Start while running is ignored
    go(20, 1);
    for (int i = 0; i < 6; i++) cyc();
    chk("restart at 14", 64'(count0), 64'd14);
    go(99, 1);
    chk_all("restart");
    chk("restart ignored", 64'(count0), 64'd13);
    do_abort();

    // Auto-reload period
    go(4, 2);
    for (int i = 0; i < 6; i++) begin cyc(); chk_all("reload"); end
    chk("reload busy", 64'(busy1), 64'd1);
    do_abort();

    // Asynchronous reset mid-run at 57
    go(60, 3);
    cyc();
    chk("pre-reset", 64'(count0), 64'd57);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_all("async reset");
    @(negedge clk) rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      start      = ($urandom % 4) == 0;
      load_value = ($urandom % 6 == 0) ? '0 : W'($urandom_range(1, 40));
      decrement  = ($urandom % 8 == 0) ? 8'd0 : (($urandom % 10 == 0) ? 8'd255 : 8'($urandom_range(1, 12)));
      enable     = ($urandom % 5) != 0;
      abort      = ($urandom % 20) == 0;
      cyc();
      chk_all("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
